// File: rtl/hamming64_pkg.sv
// Shared SECDED(72,64) definitions: codeword geometry, parity-position table,
// data-position map and syndrome / data-extraction helpers. Used by both the
// encoder and the decoder so the two sides always agree on the layout.
package hamming64_pkg;

  localparam int CW_W   = 72;
  localparam int DATA_W = 64;
  localparam int SYN_W  = 7;

  // Hamming parity bits sit at the power-of-two positions; bit 0 is overall parity.
  localparam logic [SYN_W-1:0] PAR_POS [SYN_W] =
    '{7'd1, 7'd2, 7'd4, 7'd8, 7'd16, 7'd32, 7'd64};

  function automatic logic is_par_pos(input int p);
    for (int k = 0; k < SYN_W; k++)
      if (p == int'(PAR_POS[k])) return 1'b1;
    return 1'b0;
  endfunction

  // Codeword position of data bit idx: data fills the non-parity slots from 3 upward.
  function automatic logic [SYN_W-1:0] data_pos(input int idx);
    logic [SYN_W-1:0] r;
    int n;
    r = '0;
    n = 0;
    for (int p = 3; p < CW_W; p++) begin
      if (!is_par_pos(p)) begin
        if (n == idx) r = SYN_W'(p);
        n++;
      end
    end
    return r;
  endfunction

  // XOR of the indices of all set bits == per-bit XOR over positions with bit k set.
  function automatic logic [SYN_W-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int p = 1; p < CW_W; p++)
      if (cw[p]) s ^= SYN_W'(p);
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++)
      d[i] = cw[data_pos(i)];
    return d;
  endfunction

endpackage

// File: rtl/hamming_decoding64_if.sv
// Decoder bus: codeword strobe + counter clear in, decoded data, error flags
// and statistics out. master = producer/consumer side, slave = decoder.
interface hamming_decoding64_if
  import hamming64_pkg::*;
#(
  parameter int COUNT_W = 16
);
  logic [CW_W-1:0]    codeWord;
  logic               codeWord72Done;
  logic               clearCounts;
  logic [DATA_W-1:0]  dataOut;
  logic               dataOut64Done;
  logic               singleErr;
  logic               doubleErr;
  logic [SYN_W-1:0]   errPos;
  logic [COUNT_W-1:0] correctedCount;
  logic [COUNT_W-1:0] uncorrectableCount;

  modport master (
    output codeWord, codeWord72Done, clearCounts,
    input  dataOut, dataOut64Done, singleErr, doubleErr, errPos,
           correctedCount, uncorrectableCount
  );

  modport slave (
    input  codeWord, codeWord72Done, clearCounts,
    output dataOut, dataOut64Done, singleErr, doubleErr, errPos,
           correctedCount, uncorrectableCount
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk, rst (async high), clr_i, inc_i, cnt_o[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (inc_i && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hamming_decoding64.sv
// Two-stage SECDED(72,64) decoder with error statistics.
// Stage 1 captures the codeword, syndrome and overall parity on a strobe;
// stage 2 corrects/classifies and registers the result, so dataOut64Done
// pulses two cycles after codeWord72Done. Fully pipelined, no stalls.
// Ports: clk, reset (async high), bus (slave modport: codeword in,
// data/flags/errPos/counters out).
module hamming_decoding64
  import hamming64_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  hamming_decoding64_if.slave  bus
);
  localparam int STAGES = 2;
  localparam logic [SYN_W-1:0] MAX_POS = SYN_W'(CW_W - 1);

  logic [STAGES:1]    vld_pipe_q;
  logic [CW_W-1:0]    cw_q;
  logic [SYN_W-1:0]   syn_q;
  logic               par_q;

  logic [CW_W-1:0]    cw_fix;
  logic [DATA_W-1:0]  data_d, data_q;
  logic               sgl_d, sgl_q, dbl_d, dbl_q;
  logic [SYN_W-1:0]   pos_d, pos_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) vld_pipe_q <= '0;
    else       vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.codeWord72Done};

  // Stage 1
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cw_q  <= '0;
      syn_q <= '0;
      par_q <= 1'b0;
    end else if (bus.codeWord72Done) begin
      cw_q  <= bus.codeWord;
      syn_q <= syndrome(bus.codeWord);
      par_q <= ^bus.codeWord;
    end

  // Stage 2 classification. s==0,p==1 means only bit 0 was hit: data is intact.
  // A syndrome beyond the last position cannot be a single error.
  always_comb begin
    cw_fix = cw_q;
    sgl_d  = 1'b0;
    dbl_d  = 1'b0;
    pos_d  = '0;
    if (syn_q == '0) begin
      sgl_d = par_q;
    end else if (par_q && syn_q <= MAX_POS) begin
      cw_fix = cw_q ^ ({{(CW_W-1){1'b0}}, 1'b1} << syn_q);
      sgl_d  = 1'b1;
      pos_d  = syn_q;
    end else begin
      dbl_d = 1'b1;
    end
    data_d = extract_data(cw_fix);
  end

  // Results hold until the next word reaches stage 2.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_q <= '0;
      sgl_q  <= 1'b0;
      dbl_q  <= 1'b0;
      pos_q  <= '0;
    end else if (vld_pipe_q[1]) begin
      data_q <= data_d;
      sgl_q  <= sgl_d;
      dbl_q  <= dbl_d;
      pos_q  <= pos_d;
    end

  // Counters step on the same edge the result lands, so they already include
  // the word during its dataOut64Done cycle.
  sat_counter #(.W(COUNT_W)) u_cor_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (bus.clearCounts),
    .inc_i (vld_pipe_q[1] & sgl_d),
    .cnt_o (bus.correctedCount)
  );

  sat_counter #(.W(COUNT_W)) u_unc_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (bus.clearCounts),
    .inc_i (vld_pipe_q[1] & dbl_d),
    .cnt_o (bus.uncorrectableCount)
  );

  assign bus.dataOut       = data_q;
  assign bus.dataOut64Done = vld_pipe_q[STAGES];
  assign bus.singleErr     = sgl_q;
  assign bus.doubleErr     = dbl_q;
  assign bus.errPos        = pos_q;
endmodule

// File: tb/tb_hamming_decoding64.sv
// Directed bench for hamming_decoding64 (counters built 2 bits wide so
// saturation is reachable). Codewords come from an independent encoder;
// expected outputs are written out by hand.
module tb_hamming_decoding64;
  localparam int CNTW = 2;
  localparam logic [63:0] D = 64'hAAAA00AAAAFFAAAA;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hamming_decoding64_if #(.COUNT_W(CNTW)) bus ();
  hamming_decoding64 #(.COUNT_W(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] enc(input logic [63:0] d);
    logic [71:0] c;
    logic x;
    int n;
    c = '0;
    n = 0;
    for (int p = 3; p < 72; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[n];
        n++;
      end
    for (int k = 0; k < 7; k++) begin
      x = 1'b0;
      for (int p = 1; p < 72; p++)
        if (((p >> k) & 1) == 1) x ^= c[p];
      c[1 << k] = x;
    end
    c[0] = ^c[71:1];
    return c;
  endfunction

  function automatic logic [71:0] fl(input logic [71:0] cw, input int p);
    return cw ^ (72'd1 << p);
  endfunction

  task automatic chk_res(input string tag, input logic [63:0] ed, input logic s,
                         input logic d, input int p, input int cc, input int uc);
    chk({tag, ".done"}, 64'(bus.dataOut64Done), 64'd1);
    chk({tag, ".data"}, bus.dataOut, ed);
    chk({tag, ".sgl"},  64'(bus.singleErr), 64'(s));
    chk({tag, ".dbl"},  64'(bus.doubleErr), 64'(d));
    chk({tag, ".pos"},  64'(bus.errPos), 64'(p));
    chk({tag, ".cc"},   64'(bus.correctedCount), 64'(cc));
    chk({tag, ".uc"},   64'(bus.uncorrectableCount), 64'(uc));
  endtask

  // Single word: strobe, expect nothing at N+1, result at N+2, held at N+3.
  task automatic dec(input string tag, input logic [71:0] cw, input logic [63:0] ed,
                     input logic s, input logic d, input int p, input int cc, input int uc);
    bus.codeWord       = cw;
    bus.codeWord72Done = 1'b1;
    step();
    bus.codeWord72Done = 1'b0;
    chk({tag, ".early"}, 64'(bus.dataOut64Done), 64'd0);
    step();
    chk_res(tag, ed, s, d, p, cc, uc);
    step();
    chk({tag, ".pulse"}, 64'(bus.dataOut64Done), 64'd0);
    chk({tag, ".hold"}, bus.dataOut, ed);
  endtask

  task automatic clear_counts();
    bus.clearCounts = 1'b1;
    step();
    bus.clearCounts = 1'b0;
    chk("clr.cc", 64'(bus.correctedCount), 64'd0);
    chk("clr.uc", 64'(bus.uncorrectableCount), 64'd0);
  endtask

  logic [71:0] base;
  logic [71:0] bw [4];
  logic [63:0] bd [4];
  logic        bs [4];
  logic        bdb[4];
  int          bp [4];
  int          bcc[4];
  int          buc[4];

  initial begin
    base = enc(D);
    reset = 1'b1;
    bus.codeWord = '0;
    bus.codeWord72Done = 1'b0;
    bus.clearCounts = 1'b0;
    #2;
    chk("rst.data", bus.dataOut, 64'd0);
    chk("rst.done", 64'(bus.dataOut64Done), 64'd0);
    chk("rst.flags", 64'({bus.singleErr, bus.doubleErr}), 64'd0);
    chk("rst.pos", 64'(bus.errPos), 64'd0);
    chk("rst.cnt", 64'({bus.correctedCount, bus.uncorrectableCount}), 64'd0);
    step();
    step();
    reset = 1'b0;

    // Strobe on the first edge after release.
    dec("clean", base, D, 1'b0, 1'b0, 0, 0, 0);
    dec("flip5", fl(base, 5), D, 1'b1, 1'b0, 5, 1, 0);
    dec("flip0", fl(base, 0), D, 1'b1, 1'b0, 0, 2, 0);
    dec("flip3_10", fl(fl(base, 3), 10), 64'hAAAA00AAAAFFAA8B, 1'b0, 1'b1, 0, 2, 1);
    dec("flip71", fl(base, 71), D, 1'b1, 1'b0, 71, 3, 1);
    // Syndrome 79 with odd parity: out of range, uncorrectable.
    dec("syn79", fl(fl(fl(base, 64), 12), 3), 64'hAAAA00AAAAFFAA2B, 1'b0, 1'b1, 0, 3, 2);

    // Back-to-back stream.
    clear_counts();
    bw[0] = base;               bd[0] = D;                 bs[0] = 0; bdb[0] = 0; bp[0] = 0; bcc[0] = 0; buc[0] = 0;
    bw[1] = fl(base, 7);        bd[1] = D;                 bs[1] = 1; bdb[1] = 0; bp[1] = 7; bcc[1] = 1; buc[1] = 0;
    bw[2] = fl(fl(base, 7), 9); bd[2] = 64'hAAAA00AAAAFFAAB2; bs[2] = 0; bdb[2] = 1; bp[2] = 0; bcc[2] = 1; buc[2] = 1;
    bw[3] = base;               bd[3] = D;                 bs[3] = 0; bdb[3] = 0; bp[3] = 0; bcc[3] = 1; buc[3] = 1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.codeWord = bw[i];
        bus.codeWord72Done = 1'b1;
      end else begin
        bus.codeWord72Done = 1'b0;
      end
      step();
      if (i == 0) chk("b2b.early", 64'(bus.dataOut64Done), 64'd0);
      else chk_res($sformatf("b2b%0d", i - 1), bd[i-1], bs[i-1], bdb[i-1], bp[i-1], bcc[i-1], buc[i-1]);
    end
    step();
    chk("b2b.end", 64'(bus.dataOut64Done), 64'd0);

    // Saturation and clear-beats-increment.
    clear_counts();
    for (int i = 0; i < 5; i++)
      dec($sformatf("sat%0d", i), fl(base, 5), D, 1'b1, 1'b0, 5, (i < 3) ? i + 1 : 3, 0);
    bus.codeWord = fl(base, 6);
    bus.codeWord72Done = 1'b1;
    step();
    bus.codeWord72Done = 1'b0;
    bus.clearCounts = 1'b1;
    step();
    bus.clearCounts = 1'b0;
    chk_res("satclr", D, 1'b1, 1'b0, 6, 0, 0);
    step();

    // Reset mid-pipeline.
    dec("pre_rst", fl(fl(base, 3), 10), 64'hAAAA00AAAAFFAA8B, 1'b0, 1'b1, 0, 0, 1);
    bus.codeWord = fl(base, 5);
    bus.codeWord72Done = 1'b1;
    step();
    bus.codeWord72Done = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid.data", bus.dataOut, 64'd0);
    chk("mid.flags", 64'({bus.singleErr, bus.doubleErr}), 64'd0);
    chk("mid.pos", 64'(bus.errPos), 64'd0);
    chk("mid.uc", 64'(bus.uncorrectableCount), 64'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid.nodone%0d", i), 64'(bus.dataOut64Done), 64'd0);
      step();
    end
    dec("post_rst", fl(base, 20), D, 1'b1, 1'b0, 20, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hamming_decoding64.md
HAMMING_DECODING64 -- requirements
Module: hamming_decoding64

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of each error-statistics counter.
REQ-002 SHALL have port clk  input  1  system clock (50 MHz); all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port codeWord  input  72  SECDED codeword to decode, in HammingEncoding64 layout.
REQ-005 SHALL have port codeWord72Done  input  1  one-cycle strobe marking codeWord valid this cycle.
REQ-006 SHALL have port clearCounts  input  1  synchronous clear of both statistics counters.
REQ-007 SHALL have port dataOut  output  64  decoded (corrected where possible) data.
REQ-008 SHALL have port dataOut64Done  output  1  one-cycle pulse when dataOut and flags are newly valid.
REQ-009 SHALL have port singleErr  output  1  the current result had one corrected error.
REQ-010 SHALL have port doubleErr  output  1  the current result had an uncorrectable error.
REQ-011 SHALL have port errPos  output  7  codeword position flipped on single error, else 0.
REQ-012 SHALL have port correctedCount  output  COUNT_W  saturating count of singleErr results.
REQ-013 SHALL have port uncorrectableCount  output  COUNT_W  saturating count of doubleErr results.

Function
REQ-014 SHALL use this codeword layout: bit 0 is overall parity (XOR of bits 1..71); bits 1,2,4,8,16,32,64 are Hamming parity; the remaining 64 positions carry data, dataIn[0] at position 3, ascending.
REQ-015 SHALL compute syndrome s[6:0] (bit k = XOR of positions whose index has bit k set) and overall parity p = XOR of bits 0..71.
REQ-016 SHALL register codeWord, s and p in stage 1 on a codeWord72Done cycle.
REQ-017 SHALL apply correction and drive outputs in stage 2, so dataOut64Done pulses exactly 2 cycles after codeWord72Done.
REQ-018 SHALL accept codeWord72Done on every cycle (back-to-back) with no stall and no dropped words.
REQ-019 SHALL, for s==0 and p==0, report no error: dataOut = extracted data, singleErr=0, doubleErr=0, errPos=0.
REQ-020 SHALL, for s in 1..71 and p==1, flip position s, set singleErr=1 and errPos=s.
REQ-021 SHALL, for s==0 and p==1, treat the error as lying in bit 0: data unchanged, singleErr=1, errPos=0.
REQ-022 SHALL, for s!=0 and p==0, or s>71 with p==1, set doubleErr=1 and singleErr=0, with errPos=0 and dataOut carrying the uncorrected data bits.
REQ-023 SHALL hold dataOut, singleErr, doubleErr and errPos stable between dataOut64Done pulses.
REQ-024 SHALL increment correctedCount or uncorrectableCount on the cycle of the dataOut64Done pulse, saturating at all-ones.
REQ-025 SHALL give clearCounts priority over a same-cycle increment; the counters read 0 on the next cycle.

Reset
REQ-026 SHALL, on reset assertion, immediately clear all pipeline valid flags and registers, and set dataOut=0, dataOut64Done=0, singleErr=0, doubleErr=0, errPos=0 and both counters to 0.
REQ-027 SHALL discard any word in flight when reset is asserted mid-pipeline; no dataOut64Done is produced for it after reset release.
REQ-028 SHALL accept a codeWord72Done on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place the parity-position constants, the data-position map function and the syndrome function in a shared package hamming64_pkg, which HammingEncoding64 uses as well.
REQ-030 SHALL implement the saturating counter as one sub-module sat_counter, instantiated twice.

Verification
REQ-031 Clean codeword from encoding 64'hAAAA00AAAAFFAAAA, strobe at cycle N -> dataOut64Done at N+2, dataOut=64'hAAAA00AAAAFFAAAA, both flags 0, counters unchanged.
REQ-032 Same codeword with position 5 flipped -> dataOut restored, singleErr=1, errPos=5, correctedCount=1; then position 0 flipped -> singleErr=1, errPos=0, correctedCount=2.
REQ-033 Positions 3 and 10 flipped -> doubleErr=1, singleErr=0, errPos=0, uncorrectableCount=1.
REQ-034 Four back-to-back strobes (clean, flip 7, flip 7+9, clean) -> four consecutive done pulses starting at N+2 with results in order and flags 0/1/2/0 as appropriate.
REQ-035 With COUNT_W=2, five single-error words -> correctedCount=3 (saturated); clearCounts together with a sixth error word -> correctedCount=0.
REQ-036 Reset asserted one cycle after a strobe -> outputs zero immediately and no done pulse after release; the next strobe decodes normally.
